// File: rtl/vga_rx_monitor.sv
// Receive-side checker for the 29-bit VGA bus: decodes pixel coordinates and RGB,
// verifies line/frame geometry, tracks lock, and captures one programmable pixel.
module vga_rx_monitor #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned H_TOTAL     = 800,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic [28:0] iVGA,
  input  logic [10:0] capture_x,
  input  logic [10:0] capture_y,
  output logic [10:0] rx_x,
  output logic [10:0] rx_y,
  output logic [23:0] rx_rgb,
  output logic        rx_valid,
  output logic [23:0] captured_rgb,
  output logic        capture_hit,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic        locked,
  output logic        timing_error
);

  typedef enum logic [1:0] {SEEK, MEASURE, LOCKED} state_e;

  logic [28:0] vga_q;
  logic        hs_dly_q, vs_dly_q;
  logic [10:0] x_q, x_d, x_base, y_q, y_d, y_line;
  logic        had_act_q, had_act_d;
  logic [11:0] hclk_q, hclk_d;
  logic        first_line_q, first_line_d;
  logic [11:0] lines_in_frame;
  logic        hs_fall, vs_fall, active;
  logic        line_err, frame_err, chk_err;

  logic [10:0] rx_x_q, rx_y_q;
  logic [23:0] rx_rgb_q, captured_rgb_q;
  logic        rx_valid_q, capture_hit_q;

  state_e      state_q;
  logic [15:0] good_q, frame_count_q;
  logic        locked_q, frame_done_q, timing_error_q;

  // SYNC_N and VGA_CLK carry no information for this checker.
  logic unused_sync;
  assign unused_sync = ^vga_q[28:27];

  function automatic logic [10:0] sat_inc(input logic [10:0] v);
    return (v == '1) ? v : v + 11'd1;
  endfunction

  assign hs_fall = hs_dly_q & ~vga_q[24];
  assign vs_fall = vs_dly_q & ~vga_q[25];
  assign active  = vga_q[26];

  always_comb begin
    x_base       = hs_fall ? '0 : x_q;
    x_d          = active ? sat_inc(x_base) : x_base;
    y_line       = (hs_fall && had_act_q) ? sat_inc(y_q) : y_q;
    y_d          = vs_fall ? '0 : y_line;
    had_act_d    = (hs_fall || vs_fall) ? active : (had_act_q | active);
    hclk_d       = hs_fall ? 12'd1 : ((hclk_q == '1) ? hclk_q : hclk_q + 12'd1);
    first_line_d = vs_fall ? 1'b1 : (hs_fall ? 1'b0 : first_line_q);
    // A line still holding active pixels at frame start has not been counted into y_q yet.
    lines_in_frame = {1'b0, y_q} + {11'd0, had_act_q};
    line_err  = hs_fall && ((!first_line_q && hclk_q != 12'(H_TOTAL)) ||
                            (x_q != '0 && x_q != 11'(H_ACTIVE)));
    frame_err = vs_fall && (lines_in_frame != 12'(V_ACTIVE));
    chk_err   = line_err | frame_err;
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      vga_q        <= '0;
      hs_dly_q     <= 1'b0;
      vs_dly_q     <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      had_act_q    <= 1'b0;
      hclk_q       <= '0;
      first_line_q <= 1'b0;
      rx_x_q       <= '0;
      rx_y_q       <= '0;
      rx_rgb_q     <= '0;
      rx_valid_q   <= 1'b0;
    end else begin
      vga_q        <= iVGA;
      hs_dly_q     <= vga_q[24];
      vs_dly_q     <= vga_q[25];
      x_q          <= x_d;
      y_q          <= y_d;
      had_act_q    <= had_act_d;
      hclk_q       <= hclk_d;
      first_line_q <= first_line_d;
      rx_x_q       <= x_base;
      rx_y_q       <= y_d;
      rx_rgb_q     <= vga_q[23:0];
      rx_valid_q   <= active;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      captured_rgb_q <= '0;
      capture_hit_q  <= 1'b0;
    end else begin
      capture_hit_q <= 1'b0;
      if (rx_valid_q && rx_x_q == capture_x && rx_y_q == capture_y) begin
        captured_rgb_q <= rx_rgb_q;
        capture_hit_q  <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      state_q        <= SEEK;
      good_q         <= '0;
      frame_count_q  <= '0;
      locked_q       <= 1'b0;
      frame_done_q   <= 1'b0;
      timing_error_q <= 1'b0;
    end else begin
      frame_done_q   <= 1'b0;
      timing_error_q <= 1'b0;
      case (state_q)
        SEEK: begin
          if (vs_fall) begin
            state_q <= MEASURE;
            good_q  <= '0;
          end
        end
        MEASURE: begin
          if (chk_err) begin
            timing_error_q <= 1'b1;
            state_q        <= SEEK;
          end else if (vs_fall) begin
            if ({16'd0, good_q} + 32'd1 >= LOCK_FRAMES) begin
              state_q       <= LOCKED;
              locked_q      <= 1'b1;
              frame_count_q <= '0;
              good_q        <= '0;
            end else begin
              good_q <= good_q + 16'd1;
            end
          end
        end
        LOCKED: begin
          if (chk_err) begin
            timing_error_q <= 1'b1;
            locked_q       <= 1'b0;
            state_q        <= SEEK;
          end else if (vs_fall) begin
            frame_done_q  <= 1'b1;
            frame_count_q <= frame_count_q + 16'd1;
          end
        end
        default: state_q <= SEEK;
      endcase
    end
  end

  assign rx_x         = rx_x_q;
  assign rx_y         = rx_y_q;
  assign rx_rgb       = rx_rgb_q;
  assign rx_valid     = rx_valid_q;
  assign captured_rgb = captured_rgb_q;
  assign capture_hit  = capture_hit_q;
  assign frame_done   = frame_done_q;
  assign frame_count  = frame_count_q;
  assign locked       = locked_q;
  assign timing_error = timing_error_q;

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed frame sequence with random pixel data for vga_rx_monitor, using a
// reduced geometry so many frames fit in a short run.
module tb_vga_rx_monitor;

  localparam int HA = 16;
  localparam int HT = 24;
  localparam int VA = 6;
  localparam int VT = 9;

  logic        clk = 1'b0;
  logic        resetN;
  logic [28:0] iVGA;
  logic [10:0] capture_x, capture_y;
  logic [10:0] rx_x, rx_y;
  logic [23:0] rx_rgb, captured_rgb;
  logic        rx_valid, capture_hit, frame_done, locked, timing_error;
  logic [15:0] frame_count;

  vga_rx_monitor #(
    .H_ACTIVE(HA), .V_ACTIVE(VA), .H_TOTAL(HT), .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .resetN(resetN), .iVGA(iVGA),
    .capture_x(capture_x), .capture_y(capture_y),
    .rx_x(rx_x), .rx_y(rx_y), .rx_rgb(rx_rgb), .rx_valid(rx_valid),
    .captured_rgb(captured_rgb), .capture_hit(capture_hit),
    .frame_done(frame_done), .frame_count(frame_count),
    .locked(locked), .timing_error(timing_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        c;
    int          x;
    int          y;
    logic [23:0] rgb;
  } exp_t;

  exp_t        hist[$];
  int          tests, fails;
  int          n_err = 0, n_done = 0, n_hit = 0;
  int          b_err, b_done, b_hit;
  logic        post_rst;
  logic        rx_chk;
  logic        tgt_en;
  logic [23:0] tgt_rgb;

  always @(negedge clk) begin
    if (timing_error) n_err++;
    if (frame_done)   n_done++;
    if (capture_hit)  n_hit++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One pixel clock: check outputs two drives back, then drive the next bus word.
  task automatic cyc(input logic hs_n, input logic vs_n, input logic bl,
                     input logic [23:0] rgb, input int ex, input int ey, input logic rst);
    exp_t e;
    @(posedge clk);
    #1;
    if (post_rst) begin
      chk("rst_rx_valid", 32'(rx_valid), 0);
      chk("rst_rx_xy", {10'd0, rx_x, rx_y}, 0);
      chk("rst_rx_rgb", 32'(rx_rgb), 0);
      chk("rst_captured", 32'(captured_rgb), 0);
      chk("rst_pulses", {29'd0, capture_hit, frame_done, timing_error}, 0);
      chk("rst_frame_count", 32'(frame_count), 0);
      chk("rst_locked", 32'(locked), 0);
      post_rst = 1'b0;
    end else if (hist.size() == 2) begin
      e = hist.pop_front();
      chk("rx_valid", 32'(rx_valid), 32'(e.v));
      if (e.v && e.c) begin
        chk("rx_x", 32'(rx_x), e.x);
        chk("rx_y", 32'(rx_y), e.y);
        chk("rx_rgb", 32'(rx_rgb), 32'(e.rgb));
      end
    end
    iVGA   = {1'($urandom), 1'($urandom), bl, vs_n, hs_n, rgb};
    resetN = ~rst;
    if (rst) begin
      hist.delete();
      post_rst = 1'b1;
      rx_chk   = 1'b0;
    end else begin
      e.v = bl; e.c = rx_chk; e.x = ex; e.y = ey; e.rgb = rgb;
      hist.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b1, 1'b0, 24'($urandom), 0, 0, 1'b0);
  endtask

  // Frame layout: line 0 carries VS low; lines 2..VA+1 are active; HS low for h<3;
  // active pixels at h=4..4+HA-1.  Fault knobs shorten/lengthen/blank one line.
  task automatic send_frame(input int short_aline, input int long_v, input int skip_v,
                            input int rst_v, input int rst_h, input logic force_cnt);
    int          ay, len, npix, px;
    logic        act_line, hs, vs, bl, rst;
    logic [23:0] rgb;
    rx_chk = 1'b1;
    ay = 0;
    for (int v = 0; v < VT; v++) begin
      len      = (v == long_v) ? HT + 1 : HT;
      act_line = (v >= 2) && (v < 2 + VA) && (v != skip_v);
      npix     = (act_line && ay == short_aline) ? HA - 1 : HA;
      for (int h = 0; h < len; h++) begin
        hs  = (h >= 3);
        vs  = (v != 0);
        px  = h - 4;
        bl  = act_line && (h >= 4) && (px < npix);
        rgb = 24'($urandom);
        if (bl && tgt_en && px == int'(capture_x) && ay == int'(capture_y)) rgb = tgt_rgb;
        rst = (v == rst_v) && (h == rst_h);
        if (force_cnt && v == VT - 1 && h == len - 1) force dut.frame_count_q = 16'hFFFF;
        cyc(hs, vs, bl, rgb, px, ay, rst);
      end
      if (act_line) ay++;
    end
    if (force_cnt) release dut.frame_count_q;
  endtask

  task automatic clean_frame();
    send_frame(-1, -1, -1, -1, -1, 1'b0);
  endtask

  initial begin
    resetN = 1'b0; iVGA = '0; capture_x = '0; capture_y = '0;
    tests = 0; fails = 0; post_rst = 1'b0; rx_chk = 1'b1;
    tgt_en = 1'b0; tgt_rgb = '0;

    cyc(1'b1, 1'b1, 1'b0, '0, 0, 0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, '0, 0, 0, 1'b1);
    idle(6);
    b_err = n_err; b_done = n_done;

    clean_frame();
    clean_frame();
    chk("lock_after_2_vs", 32'(locked), 0);
    clean_frame();
    chk("lock_after_3_vs", 32'(locked), 1);
    chk("fc_at_lock", 32'(frame_count), 0);
    chk("done_while_acquiring", n_done - b_done, 0);

    capture_x = 11'd0; capture_y = 11'd0; tgt_en = 1'b1; tgt_rgb = 24'hFF0000;
    b_hit = n_hit; b_done = n_done;
    clean_frame();
    chk("cap_origin_rgb", 32'(captured_rgb), 32'h00FF0000);
    chk("cap_origin_hits", n_hit - b_hit, 1);
    chk("done_frame4", n_done - b_done, 1);
    chk("fc_frame4", 32'(frame_count), 1);

    capture_x = 11'(HA - 1); capture_y = 11'(VA - 1); tgt_rgb = 24'h00FF00;
    b_hit = n_hit;
    clean_frame();
    chk("cap_corner_rgb", 32'(captured_rgb), 32'h0000FF00);
    chk("cap_corner_hits", n_hit - b_hit, 1);
    chk("fc_frame5", 32'(frame_count), 2);
    chk("no_err_clean", n_err - b_err, 0);
    tgt_en = 1'b0;

    b_err = n_err; b_done = n_done;
    send_frame(1, -1, -1, -1, -1, 1'b0);
    chk("short_line_err", n_err - b_err, 1);
    chk("short_line_unlock", 32'(locked), 0);
    chk("short_line_done", n_done - b_done, 1);

    b_err = n_err;
    clean_frame();
    clean_frame();
    chk("relock_not_yet", 32'(locked), 0);
    clean_frame();
    chk("relock", 32'(locked), 1);
    chk("relock_fc", 32'(frame_count), 0);
    chk("relock_no_err", n_err - b_err, 0);

    b_err = n_err;
    send_frame(-1, 4, -1, -1, -1, 1'b0);
    chk("long_line_err", n_err - b_err, 1);
    chk("long_line_unlock", 32'(locked), 0);

    clean_frame();
    clean_frame();
    clean_frame();
    b_err = n_err;
    send_frame(-1, -1, 5, -1, -1, 1'b0);
    chk("short_frame_no_err_yet", n_err - b_err, 0);
    chk("short_frame_still_locked", 32'(locked), 1);
    b_err = n_err; b_done = n_done;
    clean_frame();
    chk("short_frame_err", n_err - b_err, 1);
    chk("short_frame_no_done", n_done - b_done, 0);
    chk("short_frame_unlock", 32'(locked), 0);

    clean_frame();
    clean_frame();
    send_frame(-1, -1, -1, -1, -1, 1'b1);
    chk("relock_before_wrap", 32'(locked), 1);
    b_done = n_done;
    clean_frame();
    chk("fc_wrap", 32'(frame_count), 0);
    chk("wrap_done", n_done - b_done, 1);

    send_frame(-1, -1, -1, 3, 8, 1'b0);
    chk("after_rst_unlocked", 32'(locked), 0);
    clean_frame();
    clean_frame();
    chk("after_rst_seek", 32'(locked), 0);
    clean_frame();
    chk("after_rst_relock", 32'(locked), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
